// File: rtl/pipeline_stage_reg.sv
// Elastic pipeline stage register with valid/ready handshake, nullify/stall/bubble
// control (priority reset > nullify > stall > bubble > normal), an optional skid
// entry that lets in_ready be registered, and saturating stall/bubble counters.
module pipeline_stage_reg #(
    parameter int WIDTH = 64,
    parameter int SKID  = 1,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             nullify,
    input  logic             stall,
    input  logic             bubble,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready,
    output logic [1:0]       occupancy,
    output logic [CNT_W-1:0] stall_count,
    output logic [CNT_W-1:0] bubble_count
);

    localparam bit             USE_SKID = (SKID != 0);
    localparam logic [CNT_W-1:0] CNT_ONE = 1;

    logic             skid_valid;
    logic [WIDTH-1:0] skid_data;
    logic             in_ready_r;

    logic             acc;
    logic             adv;
    logic             n_out_valid;
    logic [WIDTH-1:0] n_out_data;
    logic             n_skid_valid;
    logic [WIDTH-1:0] n_skid_data;

    // Downstream can take a new word when nothing blocks the main register.
    assign adv = !stall && !bubble && (out_ready || !out_valid);

    // Without a skid the stage can only accept what it can place this cycle, so
    // in_ready is combinational; with a skid it is simply "skid is empty", registered.
    assign in_ready = USE_SKID ? in_ready_r
                               : (!reset && !nullify && adv);

    assign acc       = in_valid && in_ready;
    assign occupancy = {1'b0, out_valid} + {1'b0, skid_valid};

    // Next-state for the main register and skid entry (reset applied in the flop block).
    always_comb begin
        n_out_valid  = out_valid;
        n_out_data   = out_data;
        n_skid_valid = skid_valid;
        n_skid_data  = skid_data;
        if (nullify) begin
            // Flush everything; a same-cycle acceptance is dropped too.
            n_out_valid  = 1'b0;
            n_out_data   = '0;
            n_skid_valid = 1'b0;
            n_skid_data  = '0;
        end else if (stall || bubble) begin
            if (bubble && !stall) begin
                n_out_valid = 1'b0;
                n_out_data  = '0;
            end
            // in_ready=1 implies the skid is empty, so acc can always park there.
            if (USE_SKID && acc) begin
                n_skid_valid = 1'b1;
                n_skid_data  = in_data;
            end
        end else if (adv) begin
            if (USE_SKID && skid_valid) begin
                // Drain the older skid word first to keep FIFO order.
                n_out_valid  = 1'b1;
                n_out_data   = skid_data;
                n_skid_valid = acc;
                if (acc) n_skid_data = in_data;
            end else begin
                n_out_valid = acc;
                if (acc) n_out_data = in_data;
            end
        end else if (USE_SKID && acc) begin
            n_skid_valid = 1'b1;
            n_skid_data  = in_data;
        end
    end

    // State registers; in_ready_r is held low through reset and rises one cycle later.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid  <= 1'b0;
            out_data   <= '0;
            skid_valid <= 1'b0;
            skid_data  <= '0;
            in_ready_r <= 1'b0;
        end else begin
            out_valid  <= n_out_valid;
            out_data   <= n_out_data;
            skid_valid <= n_skid_valid;
            skid_data  <= n_skid_data;
            in_ready_r <= !n_skid_valid;
        end
    end

    // Saturating performance counters; stall takes precedence over bubble.
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_count  <= '0;
            bubble_count <= '0;
        end else begin
            if (!nullify && stall && out_valid && !(&stall_count))
                stall_count <= stall_count + CNT_ONE;
            if (!nullify && bubble && !stall && !(&bubble_count))
                bubble_count <= bubble_count + CNT_ONE;
        end
    end

endmodule
